// File: rtl/id_issue_sb.sv
// Decode/issue stage: register file, per-register pending-write scoreboard
// and registered ID/EX output with valid/ready handshake.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   in_*                     pre-decoded instruction from IF/ID + handshake
//   flush                    kill the ID instruction and the output register
//   out_*                    registered ID/EX bundle + handshake toward EX
//   wb_retire/wb_rd/wb_we/wb_data  retire + writeback from MEM/WB
//   hazard                   in_valid blocked by the scoreboard
//   sb_err                   sticky: retire seen on a zero counter
//
// Optional feature macro: ID_SB_ZERO_REG_EN (register 0 hardwired to zero,
// never tracked by the scoreboard).
module id_issue_sb #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int CTRL_W = 12,
    parameter int PC_W   = 16,
    parameter int SB_W   = 2,
    parameter logic [DATA_W-1:0] SP_RESET = 16'hFFFF,
    localparam int REG_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_rs_used,
    input  logic              in_rt_used,
    input  logic              in_rd_we,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_rd_we,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PC_W-1:0]   out_pc,
    input  logic              wb_retire,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              wb_we,
    input  logic [DATA_W-1:0] wb_data,
    output logic              hazard,
    output logic              sb_err
);

`ifdef ID_SB_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    localparam logic [SB_W-1:0] CNT_MAX = '1;
    localparam logic [SB_W-1:0] CNT_ONE = SB_W'(1);

    logic [DATA_W-1:0] rf_q  [NREGS];
    logic [SB_W-1:0]   cnt_q [NREGS];
    logic [SB_W-1:0]   cnt_d [NREGS];
    logic              sb_err_q, sb_err_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_rs_q, out_rs_d;
    logic [DATA_W-1:0] out_rt_q, out_rt_d;
    logic [REG_W-1:0]  out_rd_q, out_rd_d;
    logic              out_we_q, out_we_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [PC_W-1:0]   out_pc_q, out_pc_d;

    logic wb_wr, wb_dec, in_cnt;
    logic rs_blk, rt_blk, waw_blk, issue;
    logic [DATA_W-1:0] rs_data, rt_data;

    // Register 0 in zero-reg mode: writes dropped, scoreboard ignores it,
    // so it stays at its reset value of 0.
    assign wb_wr  = wb_retire && wb_we && !(ZERO_REG && wb_rd == '0);
    assign wb_dec = wb_retire && !(ZERO_REG && wb_rd == '0);
    assign in_cnt = in_rd_we && !(ZERO_REG && in_rd == '0);

    // A source waiting on its last pending write is released when that
    // write commits this cycle (the value is forwarded below).
    assign rs_blk = in_rs_used && cnt_q[in_rs] != '0 &&
                    !(wb_wr && wb_rd == in_rs && cnt_q[in_rs] == CNT_ONE);
    assign rt_blk = in_rt_used && cnt_q[in_rt] != '0 &&
                    !(wb_wr && wb_rd == in_rt && cnt_q[in_rt] == CNT_ONE);
    assign waw_blk = in_cnt && cnt_q[in_rd] == CNT_MAX &&
                     !(wb_dec && wb_rd == in_rd);

    assign hazard   = in_valid && (rs_blk || rt_blk || waw_blk);
    assign in_ready = !hazard && !flush && (!out_valid_q || out_ready);
    assign issue    = in_valid && in_ready;

    assign rs_data = (wb_wr && wb_rd == in_rs) ? wb_data : rf_q[in_rs];
    assign rt_data = (wb_wr && wb_rd == in_rt) ? wb_data : rf_q[in_rt];

    always_comb begin
        sb_err_d = sb_err_q;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue && in_cnt && in_rd == REG_W'(r)) begin
                if (!(wb_dec && wb_rd == REG_W'(r))) begin
                    cnt_d[r] = cnt_q[r] + 1'b1;
                end
            end else if (wb_dec && wb_rd == REG_W'(r)) begin
                if (cnt_q[r] == '0) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_rs_d    = out_rs_q;
        out_rt_d    = out_rt_q;
        out_rd_d    = out_rd_q;
        out_we_d    = out_we_q;
        out_ctrl_d  = out_ctrl_q;
        out_pc_d    = out_pc_q;
        if (issue) begin
            out_valid_d = 1'b1;
            out_rs_d    = rs_data;
            out_rt_d    = rt_data;
            out_rd_d    = in_rd;
            out_we_d    = in_rd_we;
            out_ctrl_d  = in_ctrl;
            out_pc_d    = in_pc;
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                rf_q[r] <= (r == NREGS - 1) ? SP_RESET : '0;
            end
        end else if (wb_wr) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            sb_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_rs_q    <= '0;
            out_rt_q    <= '0;
            out_rd_q    <= '0;
            out_we_q    <= 1'b0;
            out_ctrl_q  <= '0;
            out_pc_q    <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            sb_err_q    <= sb_err_d;
            out_valid_q <= out_valid_d;
            out_rs_q    <= out_rs_d;
            out_rt_q    <= out_rt_d;
            out_rd_q    <= out_rd_d;
            out_we_q    <= out_we_d;
            out_ctrl_q  <= out_ctrl_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_rs_data = out_rs_q;
    assign out_rt_data = out_rt_q;
    assign out_rd      = out_rd_q;
    assign out_rd_we   = out_we_q;
    assign out_ctrl    = out_ctrl_q;
    assign out_pc      = out_pc_q;
    assign sb_err      = sb_err_q;

endmodule

// File: tb/tb_id_issue_sb.sv
// Scoreboard testbench for id_issue_sb: directed scenarios plus random
// traffic checked against an in-flight-list reference model.
module tb_id_issue_sb;
    localparam int DW = 16;
    localparam int NR = 16;
    localparam int RW = 4;
    localparam int CW = 12;
    localparam int PW = 16;
    localparam int MAXP = 3;

`ifdef ID_SB_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid, in_ready;
    logic [RW-1:0] in_rs, in_rt, in_rd;
    logic          in_rs_used, in_rt_used, in_rd_we;
    logic [CW-1:0] in_ctrl;
    logic [PW-1:0] in_pc;
    logic          flush;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_rs_data, out_rt_data;
    logic [RW-1:0] out_rd;
    logic          out_rd_we;
    logic [CW-1:0] out_ctrl;
    logic [PW-1:0] out_pc;
    logic          wb_retire;
    logic [RW-1:0] wb_rd;
    logic          wb_we;
    logic [DW-1:0] wb_data;
    logic          hazard, sb_err;

    id_issue_sb dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_rs_used(in_rs_used), .in_rt_used(in_rt_used),
        .in_rd_we(in_rd_we), .in_ctrl(in_ctrl), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
        .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_ctrl(out_ctrl), .out_pc(out_pc),
        .wb_retire(wb_retire), .wb_rd(wb_rd), .wb_we(wb_we),
        .wb_data(wb_data),
        .hazard(hazard), .sb_err(sb_err)
    );

    typedef struct {
        logic [DW-1:0] rs_d;
        logic [DW-1:0] rt_d;
        logic [RW-1:0] rd;
        logic          we;
        logic [CW-1:0] ctrl;
        logic [PW-1:0] pc;
    } exp_t;

    typedef struct {
        int rd;
        bit killed;
    } ifl_t;

    // Model: architectural values, instructions that left the output
    // register but have not retired, and the output register content.
    exp_t          expq[$];
    ifl_t          retq[$];
    logic [DW-1:0] m_regs [NR];
    bit            m_ov, m_out_cnt, m_err;
    int            m_out_rd;
    int            n_chk, n_err;
    exp_t          mon_e;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    function automatic int pend(input int r);
        int c = 0;
        foreach (retq[i]) if (retq[i].rd == r) c++;
        if (m_ov && m_out_cnt && m_out_rd == r) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_regs[r] = (r == NR - 1) ? 16'hFFFF : 16'h0;
        expq.delete();
        retq.delete();
        m_ov = 0;
        m_out_cnt = 0;
        m_out_rd = 0;
        m_err = 0;
    endtask

    task automatic cyc(input bit v, input int rs, input int rt, input int rd,
                       input bit rsu, input bit rtu, input bit rdwe,
                       input bit ordy, input bit fl, input bit ret,
                       input int wrd, input bit wwe, input logic [DW-1:0] wd,
                       output bit h);
        bit wr_ok, bs, bt, waw, eh, er, iss;
        int idx;
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_rs = RW'(rs);
        in_rt = RW'(rt);
        in_rd = RW'(rd);
        in_rs_used = rsu;
        in_rt_used = rtu;
        in_rd_we = rdwe;
        in_ctrl = CW'($urandom);
        in_pc = PW'($urandom);
        flush = fl;
        out_ready = ordy;
        wb_retire = ret;
        wb_rd = RW'(wrd);
        wb_we = wwe;
        wb_data = wd;
        #1;
        wr_ok = ret && wwe && !(ZR && wrd == 0);
        bs = rsu && pend(rs) > 0 && !(wr_ok && wrd == rs && pend(rs) == 1);
        bt = rtu && pend(rt) > 0 && !(wr_ok && wrd == rt && pend(rt) == 1);
        waw = rdwe && pend(rd) == MAXP && !(ret && wrd == rd);
        eh = v && (bs || bt || waw);
        er = !eh && !fl && (!m_ov || ordy);
        h = hazard;
        chk("hazard", 32'(hazard), 32'(eh));
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("sb_err", 32'(sb_err), 32'(m_err));
        iss = v && er;
        if (iss) begin
            e.rs_d = (wr_ok && wrd == rs) ? wd : m_regs[rs];
            e.rt_d = (wr_ok && wrd == rt) ? wd : m_regs[rt];
            e.rd = RW'(rd);
            e.we = rdwe;
            e.ctrl = in_ctrl;
            e.pc = in_pc;
            expq.push_back(e);
        end
        @(posedge clk);
        if (ret && !(ZR && wrd == 0)) begin
            idx = -1;
            foreach (retq[i]) if (idx < 0 && retq[i].rd == wrd) idx = i;
            if (idx >= 0) retq.delete(idx);
            else m_err = 1;
        end
        if (wr_ok) m_regs[wrd] = wd;
        if (fl) begin
            if (m_ov) begin
                if (m_out_cnt) retq.push_back('{m_out_rd, 1'b1});
                if (expq.size() > 0) expq.delete(0);
            end
            m_ov = 0;
        end else if (iss) begin
            if (m_ov && m_out_cnt) retq.push_back('{m_out_rd, 1'b0});
            m_ov = 1;
            m_out_rd = rd;
            m_out_cnt = rdwe && !(ZR && rd == 0);
        end else if (m_ov && ordy) begin
            if (m_out_cnt) retq.push_back('{m_out_rd, 1'b0});
            m_ov = 0;
        end
    endtask

    task automatic drain();
        bit h;
        for (int i = 0; i < 100; i++) begin
            if (retq.size() == 0 && !m_ov) break;
            if (retq.size() > 0)
                cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, retq[0].rd,
                    !retq[0].killed, DW'($urandom), h);
            else
                cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0, h);
        end
        chk("drain_empty", 32'(retq.size()) + 32'(m_ov), 32'd0);
    endtask

    always @(negedge clk) begin
        #2;
        if (rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL transfer at %0t: got out_valid=1 expected none",
                         $time);
            end else begin
                mon_e = expq.pop_front();
                chk("out_rs_data", 32'(out_rs_data), 32'(mon_e.rs_d));
                chk("out_rt_data", 32'(out_rt_data), 32'(mon_e.rt_d));
                chk("out_rd", 32'(out_rd), 32'(mon_e.rd));
                chk("out_rd_we", 32'(out_rd_we), 32'(mon_e.we));
                chk("out_ctrl", 32'(out_ctrl), 32'(mon_e.ctrl));
                chk("out_pc", 32'(out_pc), 32'(mon_e.pc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h, v, fl, ret, wwe, ordy;
        int wrd;
        logic [64:0] snap;
        n_chk = 0;
        n_err = 0;
        in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_rs_used = 0; in_rt_used = 0; in_rd_we = 0;
        in_ctrl = 0; in_pc = 0; flush = 0; out_ready = 0;
        wb_retire = 0; wb_rd = 0; wb_we = 0; wb_data = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sb_err", 32'(sb_err), 32'd0);
        chk("rst_out_rs_data", 32'(out_rs_data), 32'd0);
        chk("rst_out_pc", 32'(out_pc), 32'd0);
        rst = 1;

        // reset values of r15 and r3
        cyc(1, 15, 3, 0, 1, 1, 0, 1, 0, 0, 0, 0, 16'h0, h);
        chk("t1_hazard", 32'(h), 32'd0);

        // RAW hazard released by a same-cycle writeback
        cyc(1, 0, 0, 3, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0, h);
        cyc(1, 3, 0, 5, 1, 0, 0, 1, 0, 0, 0, 0, 16'h0, h);
        chk("t2_hazard", 32'(h), 32'd1);
        cyc(1, 3, 0, 5, 1, 0, 0, 1, 0, 1, 3, 1, 16'h00A5, h);
        chk("t2_release", 32'(h), 32'd0);
        drain();

        // WAW saturation at three writers
        repeat (3) cyc(1, 0, 0, 4, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0, h);
        repeat (2) begin
            cyc(1, 0, 0, 4, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0, h);
            chk("t3_waw", 32'(h), 32'd1);
        end
        cyc(1, 0, 0, 4, 0, 0, 1, 1, 0, 1, 4, 1, 16'h0044, h);
        chk("t3_release", 32'(h), 32'd0);
        drain();

        // backpressure: outputs held while out_ready=0
        cyc(1, 1, 2, 7, 1, 1, 0, 1, 0, 0, 0, 0, 16'h0, h);
        #1;
        snap = {out_rs_data, out_rt_data, out_rd, out_rd_we, out_ctrl, out_pc};
        repeat (5) begin
            cyc(1, 2, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0, h);
            #1;
            chk("t4_stable", 32'({out_rs_data, out_rt_data, out_rd, out_rd_we,
                out_ctrl, out_pc} == snap), 32'd1);
        end
        cyc(1, 2, 1, 8, 1, 1, 0, 1, 0, 0, 0, 0, 16'h0, h);
        drain();

        // flush of a writer still counted until a release-only retire
        cyc(1, 0, 0, 6, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0, h);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0, h);
        #1;
        chk("t5_flush_valid", 32'(out_valid), 32'd0);
        cyc(1, 6, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 16'h0, h);
        chk("t5_hazard", 32'(h), 32'd1);
        cyc(1, 6, 0, 0, 1, 0, 0, 1, 0, 1, 6, 0, 16'hDEAD, h);
        chk("t5_release_only", 32'(h), 32'd1);
        cyc(1, 6, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 16'h0, h);
        chk("t5_issue", 32'(h), 32'd0);
        drain();

`ifdef ID_SB_ZERO_REG_EN
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 16'h1234, h);
        cyc(1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 16'h0, h);
        chk("zr_hazard", 32'(h), 32'd0);
        drain();
`endif

        for (int k = 0; k < 3000; k++) begin
            v = ($urandom % 4) != 0;
            fl = ($urandom % 25) == 0;
            ordy = fl ? 1'b0 : (($urandom % 4) != 0);
            ret = retq.size() > 0 && ($urandom % 2) == 1;
            wrd = 0;
            wwe = 0;
            if (ret) begin
                wrd = retq[0].rd;
                wwe = !retq[0].killed;
            end
            cyc(v, int'($urandom % 16), int'($urandom % 16),
                int'($urandom % 16), bit'($urandom % 2), bit'($urandom % 2),
                bit'($urandom % 2), ordy, fl, ret, wrd, wwe, DW'($urandom), h);
        end
        drain();
        chk("expq_empty", 32'(expq.size()), 32'd0);

        // retire on an idle counter sets the sticky error
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 9, 0, 16'h0, h);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0, h);
        #1;
        chk("t6_sb_err", 32'(sb_err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/id_issue_sb.md
Name: id_issue_sb

Overview:
- Parametrised decode/issue stage. Successor of the single-width ID stage.
- Contains the register file (2 read ports, 1 write port), a per-register pending-write scoreboard that replaces the fixed three-stage rd compare, and a registered ID/EX output with valid/ready handshake.
- Sits between the IF/ID register and EX. Takes pre-decoded fields from the control block; the writeback/retire port comes from MEM/WB.

Parameters:
- DATA_W, 16, register data width
- NREGS, 16, register count (power of 2); REG_W = log2(NREGS)
- CTRL_W, 12, width of opaque control bundle passed to EX
- PC_W, 16, program counter width
- SB_W, 2, width of per-register pending-write counter (max 2^SB_W-1 outstanding writes)
- SP_RESET, 16'hFFFF, reset value of register NREGS-1 (stack pointer)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  instruction accepted this cycle
- in_rs, in_rt, in_rd  in  REG_W each  source 1, source 2, destination
- in_rs_used, in_rt_used  in  1 each  source is read
- in_rd_we  in  1  instruction writes in_rd
- in_ctrl  in  CTRL_W  control bundle
- in_pc  in  PC_W  instruction PC
- flush  in  1  kill the ID instruction and the output register
- out_valid  out  1  ID/EX holds an issued instruction
- out_ready  in  1  EX accepts
- out_rs_data, out_rt_data  out  DATA_W each  operands
- out_rd  out  REG_W  destination
- out_rd_we  out  1  destination write
- out_ctrl  out  CTRL_W  registered control bundle
- out_pc  out  PC_W  registered PC
- wb_retire  in  1  an issued rd_we instruction leaves the pipe
- wb_rd  in  REG_W  destination of the retiring instruction
- wb_we  in  1  commit wb_data (0 = killed instruction, release only)
- wb_data  in  DATA_W  writeback data
- hazard  out  1  in_valid blocked by scoreboard
- sb_err  out  1  sticky: retire seen on a zero counter

Behaviour:
- Reset (rst=0, async):
  - registers = 0, except register NREGS-1 = SP_RESET
  - all counters = 0
  - out_valid = 0; out_* data = 0
  - sb_err = 0
- busy[r] = cnt[r] != 0.
- src_block(s) = used(s) && busy[s] && !(wb_retire && wb_we && wb_rd==s && cnt[s]==1).
- waw_block = in_rd_we && cnt[in_rd] == max && !(wb_retire && wb_rd==in_rd).
- hazard = in_valid && (src_block(rs) || src_block(rt) || waw_block).
- in_ready = !hazard && !flush && (!out_valid || out_ready). Issue = in_valid && in_ready.
- Read path: if wb_retire && wb_we && wb_rd==src, forward wb_data (write-before-read); otherwise read the array.
- On issue, the output register loads operands, in_rd, in_rd_we, in_ctrl and in_pc; out_valid=1. Latency is 1 cycle.
- out_valid clears when out_ready && !issue. While out_valid && !out_ready, all out_* are held stable.
- Counter update per register each cycle:
  - +1 on issue with in_rd_we for that register
  - -1 on wb_retire for that register
  - both on the same register: unchanged
- Retire on a counter already at 0: counter stays 0, sb_err=1 until reset.
- flush: no issue that cycle; out_valid cleared next edge.
  - A flushed instruction already counted in the scoreboard (in the output register or beyond) must still arrive as wb_retire with wb_we=0.
  - wb_retire applies normally during flush.
- Register write: wb_retire && wb_we writes wb_data to wb_rd at the clock edge.
- Simultaneous issue and retire on the same register are both honoured.
- A mid-operation reset discards everything, including pending counts.

Optional Feature:
- Macro ID_SB_ZERO_REG_EN.
- Defined:
  - register 0 reads 0
  - writes to register 0 are dropped
  - cnt[0] is never incremented, so register 0 never causes a hazard
- Undefined: register 0 is ordinary.

Test Plan:
- Reset release → read r15 = 16'hFFFF, r3 = 0; out_valid=0; in_ready=1 once in_valid is asserted.
- Issue ADD rd=3 (we), then a consumer with rs=3 → hazard=1, in_ready=0. Assert wb_retire rd=3 we=1 data=16'h00A5 → consumer issues the same cycle with out_rs_data=16'h00A5 next edge; cnt[3]=0.
- Issue three writers to r4 (SB_W=2) → third issues (cnt=3); a fourth writer stalls until a retire for r4 arrives.
- out_ready=0 for 5 cycles with out_valid=1 → out_* stable, in_ready=0. out_ready=1 → the next instruction enters.
- flush while a writer to r6 is in the output register → out_valid=0 next edge. cnt[6] stays 1 until wb_retire rd=6 we=0; r6 value unchanged.
- wb_retire rd=9 with cnt[9]=0 → sb_err=1 and stays 1. With ID_SB_ZERO_REG_EN defined: write 16'h1234 to r0, then read r0 → 0, and hazard=0 on rs=0.
